// File: rtl/calendar_pkg.sv
// Shared definitions for the century-clock calendar sequencer.
// Holds the sequencer state encoding, the field widths and limits, month
// constants, and small helpers for stepping a field within its range and
// for the leap-year rule (year offset 0..99 stands for 2000..2099).
package calendar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INC_SEC,
        INC_MIN,
        INC_HOUR,
        INC_DAY,
        INC_MON,
        INC_YEAR,
        CLAMP
    } state_t;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 7;

    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] HOUR_MAX = 7'd23;
    localparam logic [6:0] MON_MAX  = 7'd12;
    localparam logic [6:0] YEAR_MAX = 7'd99;

    localparam logic [3:0] FEB = 4'd2;

    // Move v one step up or down inside lo..hi, wrapping at either end.
    function automatic logic [6:0] step_wrap(input logic [6:0] v,
                                             input logic [6:0] lo,
                                             input logic [6:0] hi,
                                             input logic       up);
        if (up) begin
            return (v >= hi) ? lo : v + 7'd1;
        end
        return (v <= lo) ? hi : v - 7'd1;
    endfunction

    // Every year offset divisible by 4 is leap; 2000 is leap and 2100 is
    // outside the covered range, so the century rules never apply.
    function automatic logic is_leap(input logic [6:0] year);
        return (year[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/cal_dim_lut.sv
// Days-in-month lookup.
// Ports:
//   month  in  4  month 1..12
//   year   in  7  year offset 0..99 (selects 28/29 for February)
//   dim    out 5  number of days in that month
module cal_dim_lut
    import calendar_pkg::*;
(
    input  logic [MON_W-1:0]  month,
    input  logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  dim
);

    always_comb begin
        dim = 5'd31;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            FEB:                     dim = is_leap(year) ? 5'd29 : 5'd28;
            default:                 dim = 5'd31;
        endcase
    end

endmodule

// File: rtl/calendar_sequencer.sv
// Timekeeping core of the century clock.
// Advances sec/min/hour/day/month/year on a 1 Hz tick, rippling the carry one
// field per clock. While halted (run=0) it applies the per-field up/down step
// pulses, then clamps the day after a month/year edit.
// Optional build macro: CALSEQ_ALARM_EN adds the alarm compare.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   tick_1hz                   one-cycle pulse per second
//   run                        1 = timekeeping, 0 = halted for setting
//   up_*/down_*                step pulses, s/m/h/d/mo/y
//   sec,min,hour,day,month,year  current time and date (year = offset 0..99)
//   busy                       sequencer not idle
//   sec_strobe                 pulse when a tick writes sec
//   alarm_hour/min/on, alarm_hit  (CALSEQ_ALARM_EN only)
module calendar_sequencer
    import calendar_pkg::*;
#(
    parameter int RESET_YEAR  = 0,
    parameter int RESET_MONTH = 1,
    parameter int RESET_DAY   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic              run,
    input  logic              up_s,
    input  logic              down_s,
    input  logic              up_m,
    input  logic              down_m,
    input  logic              up_h,
    input  logic              down_h,
    input  logic              up_d,
    input  logic              down_d,
    input  logic              up_mo,
    input  logic              down_mo,
    input  logic              up_y,
    input  logic              down_y,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [DAY_W-1:0]  day,
    output logic [MON_W-1:0]  month,
    output logic [YEAR_W-1:0] year,
    output logic              busy,
    output logic              sec_strobe
`ifdef CALSEQ_ALARM_EN
    ,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    input  logic              alarm_on,
    output logic              alarm_hit
`endif
);

    state_t state, state_d;
    logic   pending, pending_d;

    logic [SEC_W-1:0]  sec_d;
    logic [MIN_W-1:0]  min_d;
    logic [HOUR_W-1:0] hour_d;
    logic [DAY_W-1:0]  day_d;
    logic [MON_W-1:0]  month_d;
    logic [YEAR_W-1:0] year_d;

    logic [DAY_W-1:0] dim_cur;
    logic [DAY_W-1:0] dim_edit;
    logic [DAY_W-1:0] clamp_lim;

    cal_dim_lut u_dim_cur (
        .month (month),
        .year  (year),
        .dim   (dim_cur)
    );

    // Looks at the date being written this cycle; registered so that the
    // CLAMP cycle sees the limit of the freshly edited month/year.
    cal_dim_lut u_dim_edit (
        .month (month_d),
        .year  (year_d),
        .dim   (dim_edit)
    );

    assign busy       = (state != IDLE);
    assign sec_strobe = (state == INC_SEC);

    always_comb begin
        state_d   = state;
        pending_d = pending;
        sec_d     = sec;
        min_d     = min;
        hour_d    = hour;
        day_d     = day;
        month_d   = month;
        year_d    = year;

        case (state)
            IDLE: begin
                if (run && (tick_1hz || pending)) begin
                    state_d   = INC_SEC;
                    pending_d = 1'b0;
                end else if (!run) begin
                    // Only the lowest field with any pulse is considered;
                    // up and down together cancel.
                    if (up_s || down_s) begin
                        if (up_s ^ down_s)
                            sec_d = 6'(step_wrap({1'b0, sec}, 7'd0, SEC_MAX, up_s));
                    end else if (up_m || down_m) begin
                        if (up_m ^ down_m)
                            min_d = 6'(step_wrap({1'b0, min}, 7'd0, MIN_MAX, up_m));
                    end else if (up_h || down_h) begin
                        if (up_h ^ down_h)
                            hour_d = 5'(step_wrap({2'b0, hour}, 7'd0, HOUR_MAX, up_h));
                    end else if (up_d || down_d) begin
                        if (up_d ^ down_d)
                            day_d = 5'(step_wrap({2'b0, day}, 7'd1, {2'b0, dim_cur}, up_d));
                    end else if (up_mo || down_mo) begin
                        if (up_mo ^ down_mo) begin
                            month_d = 4'(step_wrap({3'b0, month}, 7'd1, MON_MAX, up_mo));
                            state_d = CLAMP;
                        end
                    end else if (up_y || down_y) begin
                        if (up_y ^ down_y) begin
                            year_d  = step_wrap(year, 7'd0, YEAR_MAX, up_y);
                            state_d = CLAMP;
                        end
                    end
                end
            end
            INC_SEC: begin
                sec_d   = 6'(step_wrap({1'b0, sec}, 7'd0, SEC_MAX, 1'b1));
                state_d = ({1'b0, sec} == SEC_MAX) ? INC_MIN : IDLE;
            end
            INC_MIN: begin
                min_d   = 6'(step_wrap({1'b0, min}, 7'd0, MIN_MAX, 1'b1));
                state_d = ({1'b0, min} == MIN_MAX) ? INC_HOUR : IDLE;
            end
            INC_HOUR: begin
                hour_d  = 5'(step_wrap({2'b0, hour}, 7'd0, HOUR_MAX, 1'b1));
                state_d = ({2'b0, hour} == HOUR_MAX) ? INC_DAY : IDLE;
            end
            INC_DAY: begin
                day_d   = 5'(step_wrap({2'b0, day}, 7'd1, {2'b0, dim_cur}, 1'b1));
                state_d = (day == dim_cur) ? INC_MON : IDLE;
            end
            INC_MON: begin
                month_d = 4'(step_wrap({3'b0, month}, 7'd1, MON_MAX, 1'b1));
                state_d = ({3'b0, month} == MON_MAX) ? INC_YEAR : IDLE;
            end
            INC_YEAR: begin
                year_d  = step_wrap(year, 7'd0, YEAR_MAX, 1'b1);
                state_d = IDLE;
            end
            CLAMP: begin
                if (day > clamp_lim)
                    day_d = clamp_lim;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // One-deep tick queue while a ripple or clamp is in progress.
        if ((state != IDLE) && tick_1hz && run)
            pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= 1'b0;
            sec       <= '0;
            min       <= '0;
            hour      <= '0;
            day       <= DAY_W'(RESET_DAY);
            month     <= MON_W'(RESET_MONTH);
            year      <= YEAR_W'(RESET_YEAR);
            clamp_lim <= 5'd31;
        end else begin
            state     <= state_d;
            pending   <= pending_d;
            sec       <= sec_d;
            min       <= min_d;
            hour      <= hour_d;
            day       <= day_d;
            month     <= month_d;
            year      <= year_d;
            clamp_lim <= dim_edit;
        end
    end

`ifdef CALSEQ_ALARM_EN
    // Compare against the time the carry is about to produce, so an alarm at
    // hh:mm fires on the hh:mm-1:59 -> hh:mm:00 rollover.
    logic [MIN_W-1:0]  roll_min;
    logic [HOUR_W-1:0] roll_hour;

    always_comb begin
        roll_min  = 6'(step_wrap({1'b0, min}, 7'd0, MIN_MAX, 1'b1));
        roll_hour = hour;
        if ({1'b0, min} == MIN_MAX)
            roll_hour = 5'(step_wrap({2'b0, hour}, 7'd0, HOUR_MAX, 1'b1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alarm_hit <= 1'b0;
        else
            alarm_hit <= (state == INC_SEC) && ({1'b0, sec} == SEC_MAX) && alarm_on
                         && (roll_min == alarm_min) && (roll_hour == alarm_hour);
    end
`endif

endmodule

// File: tb/tb_calendar_sequencer.sv
module tb_calendar_sequencer;

    logic        clk;
    logic        rst_n;
    logic        tick_1hz;
    logic        run;
    logic [11:0] steps;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [6:0]  year;
    logic        busy;
    logic        sec_strobe;
`ifdef CALSEQ_ALARM_EN
    logic [4:0]  alarm_hour;
    logic [5:0]  alarm_min;
    logic        alarm_on;
    logic        alarm_hit;
`endif

    localparam logic [11:0] S_UP  = 12'h001, S_DN  = 12'h002;
    localparam logic [11:0] M_UP  = 12'h004, M_DN  = 12'h008;
    localparam logic [11:0] H_UP  = 12'h010, H_DN  = 12'h020;
    localparam logic [11:0] D_UP  = 12'h040, D_DN  = 12'h080;
    localparam logic [11:0] MO_UP = 12'h100, MO_DN = 12'h200;
    localparam logic [11:0] Y_UP  = 12'h400, Y_DN  = 12'h800;

    calendar_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .run        (run),
        .up_s       (steps[0]),
        .down_s     (steps[1]),
        .up_m       (steps[2]),
        .down_m     (steps[3]),
        .up_h       (steps[4]),
        .down_h     (steps[5]),
        .up_d       (steps[6]),
        .down_d     (steps[7]),
        .up_mo      (steps[8]),
        .down_mo    (steps[9]),
        .up_y       (steps[10]),
        .down_y     (steps[11]),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .day        (day),
        .month      (month),
        .year       (year),
        .busy       (busy),
        .sec_strobe (sec_strobe)
`ifdef CALSEQ_ALARM_EN
        ,
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_on   (alarm_on),
        .alarm_hit  (alarm_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        run;
        logic [11:0] steps;
        int          e_sec, e_min, e_hour, e_day, e_month, e_year;
    } vec_t;

    vec_t vec [17];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_date(input string name, input int y, input int mo, input int d,
                              input int h, input int m, input int s);
        check({name, ".year"},  int'(year),  y);
        check({name, ".month"}, int'(month), mo);
        check({name, ".day"},   int'(day),   d);
        check({name, ".hour"},  int'(hour),  h);
        check({name, ".min"},   int'(min),   m);
        check({name, ".sec"},   int'(sec),   s);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            cyc();
        end
        check({name, ".idle"}, int'(busy), 0);
    endtask

    task automatic step(input logic [11:0] mask);
        steps = mask;
        cyc();
        steps = '0;
        wait_idle("step");
    endtask

    task automatic tick_settle(output int nbusy, output int nstrobe);
        nbusy   = 0;
        nstrobe = 0;
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            nbusy++;
            if (sec_strobe) nstrobe++;
            cyc();
        end
        check("tick_settle.idle", int'(busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, ns, max_busy, tot_strobe;

        // Each record is applied with run held for one cycle and the listed
        // step pulses; expected fields follow on from the previous record.
        vec[0]  = '{1'b0, S_UP,          1,  0,  0,  1, 1,  0};
        vec[1]  = '{1'b0, S_UP | H_UP,   2,  0,  0,  1, 1,  0};
        vec[2]  = '{1'b0, M_UP | M_DN,   2,  0,  0,  1, 1,  0};
        vec[3]  = '{1'b0, S_DN,          1,  0,  0,  1, 1,  0};
        vec[4]  = '{1'b0, M_DN,          1, 59,  0,  1, 1,  0};
        vec[5]  = '{1'b0, H_DN,          1, 59, 23,  1, 1,  0};
        vec[6]  = '{1'b0, D_DN,          1, 59, 23, 31, 1,  0};
        vec[7]  = '{1'b0, MO_UP,         1, 59, 23, 29, 2,  0};
        vec[8]  = '{1'b0, Y_UP,          1, 59, 23, 28, 2,  1};
        vec[9]  = '{1'b0, Y_DN,          1, 59, 23, 28, 2,  0};
        vec[10] = '{1'b0, Y_DN,          1, 59, 23, 28, 2, 99};
        vec[11] = '{1'b0, D_UP,          1, 59, 23,  1, 2, 99};
        vec[12] = '{1'b0, D_DN,          1, 59, 23, 28, 2, 99};
        vec[13] = '{1'b0, MO_UP | Y_UP,  1, 59, 23, 28, 3, 99};
        vec[14] = '{1'b1, S_UP,          1, 59, 23, 28, 3, 99};
        vec[15] = '{1'b0, MO_DN,         1, 59, 23, 28, 2, 99};
        vec[16] = '{1'b0, MO_UP | MO_DN, 1, 59, 23, 28, 2, 99};

        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        run      = 1'b0;
        steps    = '0;
`ifdef CALSEQ_ALARM_EN
        alarm_hour = 5'd0;
        alarm_min  = 6'd0;
        alarm_on   = 1'b0;
`endif
        #12;
        check_date("reset", 0, 1, 1, 0, 0, 0);
        check("reset.busy", int'(busy), 0);
        check("reset.sec_strobe", int'(sec_strobe), 0);
        #5;
        rst_n = 1'b1;
        cyc();

        // 60 ticks from reset
        run = 1'b1;
        max_busy   = 0;
        tot_strobe = 0;
        for (int t = 0; t < 60; t++) begin
            tick_settle(nb, ns);
            if (nb > max_busy) max_busy = nb;
            tot_strobe += ns;
            cyc();
        end
        check("sixty.strobes", tot_strobe, 60);
        check("sixty.max_busy", max_busy, 2);
        check_date("sixty", 0, 1, 1, 0, 1, 0);

        // table of set-step vectors
        run = 1'b0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            run   = vec[i].run;
            steps = vec[i].steps;
            cyc();
            steps = '0;
            wait_idle("vec");
            run = 1'b0;
            cyc();
            check_date($sformatf("vec%0d", i), vec[i].e_year, vec[i].e_month,
                       vec[i].e_day, vec[i].e_hour, vec[i].e_min, vec[i].e_sec);
        end

        // non-leap Feb 28 rollover, year 3
        step(S_DN);
        step(S_DN);
        for (int i = 0; i < 4; i++) step(Y_UP);
        check_date("pre_y3", 3, 2, 28, 23, 59, 59);
        run = 1'b1;
        tick_settle(nb, ns);
        check("y3.busy", nb, 5);
        check_date("y3_roll", 3, 3, 1, 0, 0, 0);

        // leap year 4: Feb 28 -> Feb 29 -> Mar 1
        run = 1'b0;
        step(MO_DN);
        step(D_DN);
        step(Y_UP);
        step(S_DN); step(M_DN); step(H_DN);
        check_date("pre_y4", 4, 2, 28, 23, 59, 59);
        run = 1'b1;
        tick_settle(nb, ns);
        check_date("y4_feb29", 4, 2, 29, 0, 0, 0);
        run = 1'b0;
        step(S_DN); step(M_DN); step(H_DN);
        run = 1'b1;
        tick_settle(nb, ns);
        check_date("y4_mar1", 4, 3, 1, 0, 0, 0);

        // worst-case century rollover
        run = 1'b0;
        for (int i = 0; i < 5; i++) step(Y_DN);
        for (int i = 0; i < 3; i++) step(MO_DN);
        step(D_DN);
        step(S_DN); step(M_DN); step(H_DN);
        check_date("pre_century", 99, 12, 31, 23, 59, 59);
        run = 1'b1;
        tick_settle(nb, ns);
        check("century.busy", nb, 6);
        check("century.strobe", ns, 1);
        check_date("century", 0, 1, 1, 0, 0, 0);

        // ticks during a 6-cycle ripple: one queued, one dropped
        run = 1'b0;
        step(Y_DN); step(MO_DN); step(D_DN);
        step(S_DN); step(M_DN); step(H_DN);
        run = 1'b1;
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        tot_strobe = 0;
        for (int i = 0; i < 20; i++) begin
            if (sec_strobe) tot_strobe++;
            tick_1hz = (i == 1 || i == 3);
            cyc();
        end
        tick_1hz = 1'b0;
        check("pending.strobes", tot_strobe, 2);
        check("pending.busy", int'(busy), 0);
        check_date("pending", 0, 1, 1, 0, 0, 1);

        // tick while halted is ignored and not queued
        run = 1'b0;
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        check("halted.busy", int'(busy), 0);
        run = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        check("halted.sec", int'(sec), 1);

        // reset in the middle of a ripple
        run = 1'b0;
        step(S_DN); step(S_DN); step(M_DN);
        run = 1'b1;
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        cyc();
        rst_n = 1'b0;
        #2;
        check_date("mid_reset", 0, 1, 1, 0, 0, 0);
        check("mid_reset.busy", int'(busy), 0);
        rst_n = 1'b1;
        cyc();
        cyc();
        check("mid_reset.after", int'(busy), 0);

`ifdef CALSEQ_ALARM_EN
        // alarm at 07:30, roll from 07:29:59
        run = 1'b0;
        alarm_hour = 5'd7;
        alarm_min  = 6'd30;
        alarm_on   = 1'b1;
        for (int i = 0; i < 7; i++) step(H_UP);
        for (int i = 0; i < 29; i++) step(M_UP);
        step(S_DN);
        run = 1'b1;
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            if (alarm_hit) nb++;
            cyc();
        end
        check("alarm.hits", nb, 1);
        check("alarm.hour", int'(hour), 7);
        check("alarm.min", int'(min), 30);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calendar_sequencer.md
Name: calendar_sequencer

Overview:
Timekeeping core of the century clock. It holds sec/min/hour/day/month/year and advances them on a 1 Hz tick. Carries ripple one field per clock through a sequencing FSM. While the clock is halted for setting, it applies the per-field up/down step pulses from the setting control unit and clamps the day after month/year edits. Covers years 2000-2099; the year is stored as an offset 0..99.

Parameters:
RESET_YEAR, 0, year offset loaded at reset (0..99)
RESET_MONTH, 1, month loaded at reset (1..12)
RESET_DAY, 1, day loaded at reset (must be valid for RESET_MONTH)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_1hz  in  1  one-cycle pulse, once per second
run  in  1  1 = timekeeping, 0 = halted for setting
up_s, down_s, up_m, down_m, up_h, down_h  in  1 each  step pulses for sec, min, hour
up_d, down_d, up_mo, down_mo, up_y, down_y  in  1 each  step pulses for day, month, year
sec  out  6  0..59
min  out  6  0..59
hour  out  5  0..23
day  out  5  1..days_in_month
month  out  4  1..12
year  out  7  0..99
busy  out  1  FSM not in IDLE
sec_strobe  out  1  one-cycle pulse when sec is written by a tick

Behaviour:
- Reset (async, rst_n=0): sec=min=hour=0, day=RESET_DAY, month=RESET_MONTH, year=RESET_YEAR, busy=0, sec_strobe=0, pending=0, state=IDLE.
- Reset mid-ripple discards the partial carry; no other state survives.
- States: IDLE, INC_SEC, INC_MIN, INC_HOUR, INC_DAY, INC_MON, INC_YEAR, CLAMP.
- busy = (state != IDLE), registered.
- Tick, IDLE with run=1 (or pending=1 and run=1): next state INC_SEC; pending cleared.
- INC_SEC: sec+1; sec_strobe=1 this cycle. On 59->0 go INC_MIN, else IDLE.
- INC_MIN and INC_HOUR work the same way: min wraps 59->0 and carries; hour wraps 23->0 and carries.
- INC_DAY: day == dim(month, year) -> day=1 and carry; else day+1, then IDLE.
- INC_MON: 12 -> 1 and carry; else +1, then IDLE.
- INC_YEAR: 99 -> 0; else +1, then IDLE.
- Worst-case latency from tick to settled fields is 6 cycles (year 99, Dec 31, 23:59:59 -> 00:00:00, Jan 1, year 0).
- Tick while busy: set pending=1 (one-deep); a second tick while pending is already set is dropped. Pending is serviced on the first IDLE cycle.
- Tick while run=0: ignored, pending not set.
- Leap year: year[1:0]==0. Year offset 0 (2000) is leap.
- dim: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29/28 for February, leap/non-leap.
- Set steps are accepted only in IDLE with run=0; in any other case step pulses are ignored.
- Each accepted step moves one field by ±1, wrapping within its own range, with no carry into the next field.
  - Ranges: sec/min 0..59, hour 0..23, day 1..dim(month, year), month 1..12, year 0..99.
- up and down for the same field in one cycle: no change.
- Pulses for several fields in one cycle: only the lowest field applies (sec > min > hour > day > month > year); the rest are dropped.
- After an accepted month or year step, the next state is CLAMP, which lasts 1 cycle: if day > dim(new month, new year), day = dim(...). Then IDLE.
- run rising while in CLAMP: CLAMP completes first.

Optional Feature:
CALSEQ_ALARM_EN
- Defined: adds inputs alarm_hour[4:0], alarm_min[5:0], alarm_on, and output alarm_hit.
- alarm_hit is a one-cycle pulse, registered, in the cycle after INC_SEC writes sec=0 with hour==alarm_hour, min==alarm_min, and alarm_on=1.
- Not defined: none of these ports exist, and no alarm logic is generated.

Decomposition:
- Package calendar_pkg holds:
  - state encoding constants;
  - field widths and limits (SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MON_MAX=12, YEAR_MAX=99);
  - month constants (FEB=2).
- Sub-module cal_dim_lut: combinational month/year -> dim[4:0], including the leap rule. Two instances: the current date for INC_DAY/set steps, and the post-edit date for CLAMP.

Test Plan:
- Reset, then 60 ticks with run=1 -> sec=0, min=1; sec_strobe pulses 60 times; busy never exceeds 2 cycles per tick.
- Preload year=99, month=12, day=31, 23:59:59, then one tick -> all fields 0/1/1/0:00:00; busy high exactly 6 cycles.
- Year=3, Feb 28 23:59:59, tick -> Mar 1. Year=4, same -> Feb 29, then the next-day rollover -> Mar 1.
- run=0, day=31, month=1, one up_mo pulse -> month=2, day=29 (year 0) after the CLAMP cycle. With year=1 instead -> day=28.
- run=0, up_s and up_h in the same cycle -> sec+1, hour unchanged. up_m and down_m together -> no change. A step pulse with run=1 -> ignored.
- Two ticks during one 6-cycle ripple -> one pending tick serviced, the other dropped, giving a net +2 seconds. With CALSEQ_ALARM_EN and alarm 07:30, rolling 07:29:59 -> alarm_hit pulses once.
